// File: rtl/gba_sound_pkg.sv
// Shared types and constants for the noise channel control block.
package gba_sound_pkg;

    typedef enum logic [1:0] {
        AddrNr41 = 2'd0,
        AddrNr42 = 2'd1,
        AddrNr43 = 2'd2,
        AddrNr44 = 2'd3
    } reg_addr_e;

    typedef enum logic {
        StOff = 1'b0,
        StOn  = 1'b1
    } chan_state_e;

    localparam logic [6:0] LENGTH_MAX      = 7'd64;
    localparam logic [3:0] ENV_ZERO_PERIOD = 4'd8;

    // The DAC is powered whenever initial volume or direction is non-zero.
    function automatic logic dac_enabled(input logic [7:0] nr42);
        return nr42[7:3] != 5'd0;
    endfunction

endpackage

// File: rtl/volume_envelope.sv
// Volume envelope: holds the channel volume and steps it on envelope ticks with saturation.
module volume_envelope
    import gba_sound_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       trigger_i,
    input  logic       env_tick_i,
    input  logic [7:0] nr42_i,
    output logic [3:0] volume_o
);

    logic [3:0] volume_q, volume_d;
    logic [3:0] env_timer_q, env_timer_d;
    logic [2:0] period;
    logic       dir_up;

    assign period   = nr42_i[2:0];
    assign dir_up   = nr42_i[3];
    assign volume_o = volume_q;

    always_comb begin
        volume_d    = volume_q;
        env_timer_d = env_timer_q;
        if (trigger_i) begin
            volume_d    = nr42_i[7:4];
            env_timer_d = (period == 3'd0) ? ENV_ZERO_PERIOD : {1'b0, period};
        end else if (env_tick_i && period != 3'd0) begin
            // A timer left at 0 (period changed after trigger) behaves like an expiry.
            if (env_timer_q <= 4'd1) begin
                env_timer_d = {1'b0, period};
                if (dir_up && volume_q != 4'hF) begin
                    volume_d = volume_q + 4'd1;
                end else if (!dir_up && volume_q != 4'h0) begin
                    volume_d = volume_q - 4'd1;
                end
            end else begin
                env_timer_d = env_timer_q - 4'd1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            volume_q    <= 4'd0;
            env_timer_q <= 4'd0;
        end else begin
            volume_q    <= volume_d;
            env_timer_q <= env_timer_d;
        end
    end

endmodule

// File: rtl/noise_channel_ctrl.sv
// Noise channel control: CPU registers, length counter, on/off FSM and sample output stage.
module noise_channel_ctrl
    import gba_sound_pkg::*;
(
    input  logic       system_clock,
    input  logic       reset_n,
    input  logic       reg_we,
    input  logic [1:0] reg_addr,
    input  logic [7:0] reg_wdata,
    output logic [7:0] reg_rdata,
    input  logic       length_tick,
    input  logic       envelope_tick,
    input  logic       wave,
    output logic [7:0] NR43,
    output logic       lfsr_restart,
    output logic [3:0] sample,
    output logic       channel_on
);

    reg_addr_e   addr;
    logic        wr_nr41, wr_nr42, wr_nr43, wr_nr44, trigger;
    logic        length_en_eff, length_expire;
    logic [3:0]  volume;

    logic [7:0]  nr42_q, nr42_d;
    logic [7:0]  nr43_q, nr43_d;
    logic        length_en_q, length_en_d;
    logic [6:0]  length_ctr_q, length_ctr_d;
    chan_state_e state_q, state_d;
    logic        lfsr_restart_q, lfsr_restart_d;
    logic [3:0]  sample_q, sample_d;

    assign addr    = reg_addr_e'(reg_addr);
    assign wr_nr41 = reg_we && (addr == AddrNr41);
    assign wr_nr42 = reg_we && (addr == AddrNr42);
    assign wr_nr43 = reg_we && (addr == AddrNr43);
    assign wr_nr44 = reg_we && (addr == AddrNr44);
    assign trigger = wr_nr44 && reg_wdata[7];

    // A length tick on the same edge as an NR44 write sees the new enable.
    assign length_en_eff = wr_nr44 ? reg_wdata[6] : length_en_q;

    always_comb begin
        nr42_d         = nr42_q;
        nr43_d         = nr43_q;
        length_en_d    = length_en_q;
        length_ctr_d   = length_ctr_q;
        length_expire  = 1'b0;
        state_d        = state_q;
        lfsr_restart_d = trigger;
        sample_d       = (state_q == StOn && wave) ? volume : 4'd0;

        if (wr_nr42) nr42_d = reg_wdata;
        if (wr_nr43) nr43_d = reg_wdata;
        if (wr_nr44) length_en_d = reg_wdata[6];

        if (wr_nr41) begin
            length_ctr_d = LENGTH_MAX - {1'b0, reg_wdata[5:0]};
        end else if (trigger) begin
            if (length_ctr_q == 7'd0) length_ctr_d = LENGTH_MAX;
        end else if (length_tick && length_en_eff && length_ctr_q != 7'd0) begin
            length_ctr_d  = length_ctr_q - 7'd1;
            length_expire = (length_ctr_q == 7'd1);
        end

        unique case (state_q)
            StOff: begin
                if (trigger && dac_enabled(nr42_q)) state_d = StOn;
            end
            StOn: begin
                if (trigger) begin
                    state_d = dac_enabled(nr42_q) ? StOn : StOff;
                end else if ((wr_nr42 && !dac_enabled(reg_wdata)) || length_expire) begin
                    state_d = StOff;
                end
            end
        endcase
    end

    always_ff @(posedge system_clock) begin
        if (!reset_n) begin
            nr42_q         <= 8'd0;
            nr43_q         <= 8'd0;
            length_en_q    <= 1'b0;
            length_ctr_q   <= 7'd0;
            state_q        <= StOff;
            lfsr_restart_q <= 1'b0;
            sample_q       <= 4'd0;
        end else begin
            nr42_q         <= nr42_d;
            nr43_q         <= nr43_d;
            length_en_q    <= length_en_d;
            length_ctr_q   <= length_ctr_d;
            state_q        <= state_d;
            lfsr_restart_q <= lfsr_restart_d;
            sample_q       <= sample_d;
        end
    end

    volume_envelope u_volume_envelope (
        .clk_i      (system_clock),
        .rst_ni     (reset_n),
        .trigger_i  (trigger),
        .env_tick_i (envelope_tick && !trigger),
        .nr42_i     (nr42_q),
        .volume_o   (volume)
    );

    always_comb begin
        reg_rdata = 8'hFF;
        unique case (addr)
            AddrNr41: reg_rdata = 8'hFF;
            AddrNr42: reg_rdata = nr42_q;
            AddrNr43: reg_rdata = nr43_q;
            AddrNr44: reg_rdata = {1'b1, length_en_q, 6'b111111};
        endcase
    end

    assign NR43         = nr43_q;
    assign lfsr_restart = lfsr_restart_q;
    assign sample       = sample_q;
    assign channel_on   = (state_q == StOn);

endmodule

// File: tb/tb_noise_channel_ctrl.sv
// Self-checking bench for noise_channel_ctrl using a queue of expected results per scenario.
module tb_noise_channel_ctrl;
    import gba_sound_pkg::*;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       reg_we = 1'b0;
    logic [1:0] reg_addr = 2'd0;
    logic [7:0] reg_wdata = 8'd0;
    logic [7:0] reg_rdata;
    logic       length_tick = 1'b0;
    logic       envelope_tick = 1'b0;
    logic       wave = 1'b0;
    logic [7:0] nr43_out;
    logic       lfsr_restart;
    logic [3:0] sample;
    logic       channel_on;

    int checks = 0;
    int failures = 0;
    logic [7:0] exp_q[$];
    logic [7:0] exp;

    always #5 clk = ~clk;

    noise_channel_ctrl dut (
        .system_clock  (clk),
        .reset_n       (reset_n),
        .reg_we        (reg_we),
        .reg_addr      (reg_addr),
        .reg_wdata     (reg_wdata),
        .reg_rdata     (reg_rdata),
        .length_tick   (length_tick),
        .envelope_tick (envelope_tick),
        .wave          (wave),
        .NR43          (nr43_out),
        .lfsr_restart  (lfsr_restart),
        .sample        (sample),
        .channel_on    (channel_on)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic we, input logic [1:0] a, input logic [7:0] d,
                         input logic lt, input logic et);
        reg_we = we; reg_addr = a; reg_wdata = d;
        length_tick = lt; envelope_tick = et;
        step();
        reg_we = 1'b0; length_tick = 1'b0; envelope_tick = 1'b0;
    endtask

    task automatic write_reg(input logic [1:0] a, input logic [7:0] d);
        drive(1'b1, a, d, 1'b0, 1'b0);
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        step(); step();
        reset_n = 1'b1;
        exp_q.push_back(8'hFF); exp_q.push_back(8'h00);
        exp_q.push_back(8'h00); exp_q.push_back(8'hBF);
        for (int a = 0; a < 4; a++) begin
            reg_addr = 2'(a);
            #1;
            exp = exp_q.pop_front();
            checks++;
            if (reg_rdata !== exp) begin
                failures++;
                $display("FAIL reset_readback addr=%0d got=%h want=%h", a, reg_rdata, exp);
            end
        end
        checks++;
        if ({sample, channel_on, lfsr_restart} !== 6'b0 || nr43_out !== 8'h00) begin
            failures++;
            $display("FAIL reset_outputs got sample=%h on=%b lfsr=%b nr43=%h want 0",
                     sample, channel_on, lfsr_restart, nr43_out);
        end
    endtask

    task automatic test_trigger();
        wave = 1'b1;
        write_reg(AddrNr42, 8'hF0);
        write_reg(AddrNr44, 8'h80);
        checks++;
        if (channel_on !== 1'b1 || lfsr_restart !== 1'b1) begin
            failures++;
            $display("FAIL trigger_edge got on=%b lfsr=%b want on=1 lfsr=1", channel_on, lfsr_restart);
        end
        exp_q.push_back(8'h0F);
        step();
        exp = exp_q.pop_front();
        checks++;
        if (lfsr_restart !== 1'b0 || sample !== exp[3:0]) begin
            failures++;
            $display("FAIL trigger_after got lfsr=%b sample=%h want lfsr=0 sample=%h",
                     lfsr_restart, sample, exp[3:0]);
        end
        exp_q.push_back(8'hBF);
        reg_addr = AddrNr44; #1;
        exp = exp_q.pop_front();
        checks++;
        if (reg_rdata !== exp) begin
            failures++;
            $display("FAIL nr44_readback got=%h want=%h", reg_rdata, exp);
        end
        write_reg(AddrNr43, 8'h5A);
        exp_q.push_back(8'h5A);
        reg_addr = AddrNr43; #1;
        exp = exp_q.pop_front();
        checks++;
        if (nr43_out !== exp || reg_rdata !== exp || channel_on !== 1'b1) begin
            failures++;
            $display("FAIL nr43_write got out=%h rd=%h on=%b want %h on=1",
                     nr43_out, reg_rdata, channel_on, exp);
        end
    endtask

    task automatic test_length();
        write_reg(AddrNr41, 8'h3E);
        write_reg(AddrNr44, 8'hC0);
        drive(1'b0, 2'd0, 8'd0, 1'b1, 1'b0);
        checks++;
        if (channel_on !== 1'b1) begin
            failures++;
            $display("FAIL length_first_tick got on=%b want 1", channel_on);
        end
        exp_q.push_back(8'h0F); exp_q.push_back(8'h00);
        drive(1'b0, 2'd0, 8'd0, 1'b1, 1'b0);
        exp = exp_q.pop_front();
        checks++;
        if (channel_on !== 1'b0 || sample !== exp[3:0]) begin
            failures++;
            $display("FAIL length_expiry got on=%b sample=%h want on=0 sample=%h",
                     channel_on, sample, exp[3:0]);
        end
        step();
        exp = exp_q.pop_front();
        checks++;
        if (sample !== exp[3:0]) begin
            failures++;
            $display("FAIL length_sample_off got=%h want=%h", sample, exp[3:0]);
        end
        reg_addr = AddrNr44; #1;
        checks++;
        if (reg_rdata !== 8'hFF) begin
            failures++;
            $display("FAIL nr44_len_en_readback got=%h want=ff", reg_rdata);
        end
    endtask

    task automatic test_envelope();
        write_reg(AddrNr42, 8'h31);
        write_reg(AddrNr44, 8'h80);
        step();
        exp_q.push_back(8'h03);
        exp_q.push_back(8'h02); exp_q.push_back(8'h01);
        exp_q.push_back(8'h00); exp_q.push_back(8'h00);
        exp = exp_q.pop_front();
        checks++;
        if (sample !== exp[3:0]) begin
            failures++;
            $display("FAIL env_initial got=%h want=%h", sample, exp[3:0]);
        end
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 2'd0, 8'd0, 1'b0, 1'b1);
            step();
            exp = exp_q.pop_front();
            checks++;
            if (sample !== exp[3:0]) begin
                failures++;
                $display("FAIL env_down step=%0d got=%h want=%h", i, sample, exp[3:0]);
            end
        end
        write_reg(AddrNr42, 8'hF9);
        write_reg(AddrNr44, 8'h80);
        drive(1'b0, 2'd0, 8'd0, 1'b0, 1'b1);
        drive(1'b0, 2'd0, 8'd0, 1'b0, 1'b1);
        step();
        checks++;
        if (sample !== 4'hF) begin
            failures++;
            $display("FAIL env_up_saturate got=%h want=f", sample);
        end
        write_reg(AddrNr42, 8'hA0);
        write_reg(AddrNr44, 8'h80);
        drive(1'b0, 2'd0, 8'd0, 1'b0, 1'b1);
        drive(1'b0, 2'd0, 8'd0, 1'b0, 1'b1);
        step();
        checks++;
        if (sample !== 4'hA) begin
            failures++;
            $display("FAIL env_period0_freeze got=%h want=a", sample);
        end
    endtask

    task automatic test_dac_disable();
        write_reg(AddrNr42, 8'h00);
        checks++;
        if (channel_on !== 1'b0) begin
            failures++;
            $display("FAIL dac_disable got on=%b want 0", channel_on);
        end
        write_reg(AddrNr44, 8'h80);
        checks++;
        if (channel_on !== 1'b0 || lfsr_restart !== 1'b1) begin
            failures++;
            $display("FAIL dac_off_trigger got on=%b lfsr=%b want on=0 lfsr=1",
                     channel_on, lfsr_restart);
        end
    endtask

    task automatic test_collisions();
        write_reg(AddrNr42, 8'hF0);
        write_reg(AddrNr41, 8'h3F);
        write_reg(AddrNr44, 8'hC0);
        drive(1'b1, AddrNr44, 8'hC0, 1'b1, 1'b0);
        checks++;
        if (channel_on !== 1'b1) begin
            failures++;
            $display("FAIL trig_len_collision got on=%b want 1", channel_on);
        end
        drive(1'b0, 2'd0, 8'd0, 1'b1, 1'b0);
        checks++;
        if (channel_on !== 1'b0) begin
            failures++;
            $display("FAIL trig_len_ctr_kept got on=%b want 0", channel_on);
        end
        write_reg(AddrNr42, 8'hF1);
        write_reg(AddrNr44, 8'h80);
        drive(1'b1, AddrNr44, 8'h80, 1'b0, 1'b1);
        step();
        checks++;
        if (sample !== 4'hF) begin
            failures++;
            $display("FAIL trig_env_collision got=%h want=f", sample);
        end
        drive(1'b0, 2'd0, 8'd0, 1'b0, 1'b1);
        step();
        checks++;
        if (sample !== 4'hE) begin
            failures++;
            $display("FAIL env_after_collision got=%h want=e", sample);
        end
        write_reg(AddrNr44, 8'hC0);
        drive(1'b1, AddrNr41, 8'h3F, 1'b1, 1'b0);
        checks++;
        if (channel_on !== 1'b1) begin
            failures++;
            $display("FAIL nr41_len_collision got on=%b want 1", channel_on);
        end
        drive(1'b0, 2'd0, 8'd0, 1'b1, 1'b0);
        checks++;
        if (channel_on !== 1'b0) begin
            failures++;
            $display("FAIL nr41_write_won got on=%b want 0", channel_on);
        end
        write_reg(AddrNr44, 8'h80);
        write_reg(AddrNr41, 8'h3F);
        drive(1'b1, AddrNr44, 8'h40, 1'b1, 1'b0);
        checks++;
        if (channel_on !== 1'b0) begin
            failures++;
            $display("FAIL len_en_same_edge got on=%b want 0", channel_on);
        end
    endtask

    task automatic test_reset_mid();
        write_reg(AddrNr43, 8'h33);
        write_reg(AddrNr44, 8'h80);
        reset_n = 1'b0;
        drive(1'b1, AddrNr44, 8'h80, 1'b1, 1'b1);
        reset_n = 1'b1;
        reg_addr = AddrNr42; #1;
        checks++;
        if (channel_on !== 1'b0 || lfsr_restart !== 1'b0 || nr43_out !== 8'h00 ||
            sample !== 4'h0 || reg_rdata !== 8'h00) begin
            failures++;
            $display("FAIL reset_override got on=%b lfsr=%b nr43=%h sample=%h nr42=%h want all 0",
                     channel_on, lfsr_restart, nr43_out, sample, reg_rdata);
        end
    endtask

    initial begin
        test_reset();
        test_trigger();
        test_length();
        test_envelope();
        test_dac_disable();
        test_collisions();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
